uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one byte-wide UART transmitter between NUM_REQ requesters, such as the debug console, the status reporter and the error logger.
- Round-robin arbitration.
- Message locking: a multi-byte message from one requester is never interleaved with bytes from another.
- Sits between the requesters and the UART TX core and drives that core's start/data inputs.
- Detects and releases stalled locks.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width passed to the transmitter
LOCK_TIMEOUT, 1000, clocks a locked owner may stay silent before its lock is revoked (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte available; held with data until accepted
req_data  in  NUM_REQ*DATA_WIDTH  byte for requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  byte is last of message; sampled with data
req_ready  out  NUM_REQ  one-cycle accept pulse, registered, one-hot
tx_ready  in  1  transmitter idle and able to take a byte
tx_done  in  1  one-cycle pulse when the transmitter finishes the stop bit
tx_start  out  1  one-cycle start pulse to transmitter, registered
tx_data  out  DATA_WIDTH  byte to transmit; valid when tx_start=1; held until next start
grant_id  out  clog2(NUM_REQ)  current/last granted requester
locked  out  1  a message is in progress; only grant_id may be served
lock_timeout  out  1  one-cycle pulse when a lock is revoked

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, locked=0, lock_timeout=0, rr_ptr=0, state=IDLE, timeout counter=0.
- State IDLE:
  - Arbitrates only when tx_ready=1.
  - Unlocked: selects the first requester with req_valid=1, searching from rr_ptr upward with wrap at NUM_REQ.
  - Locked: considers only grant_id; other requesters are ignored even when valid.
  - On a selection at the edge ending cycle N: grant_id<=g, tx_data<=req_data[g], last_q<=req_last[g], tx_start<=1, req_ready[g]<=1, state<=ISSUE.
- State ISSUE (cycle N+1):
  - tx_start and req_ready[g] are high for exactly this cycle.
  - The requester may change data from N+2.
  - Next state is WAIT_DONE.
- State WAIT_DONE:
  - Waits for tx_done.
  - If last_q=1: locked<=0, rr_ptr<=g+1 (mod NUM_REQ).
  - If last_q=0: locked<=1 and rr_ptr is unchanged.
  - Then state<=IDLE.
- Minimum spacing: one IDLE cycle between tx_done and the next tx_start. Back-to-back throughput is one byte per (transmitter frame + 2 clocks).
- Timing relative to tx_done:
  - A tx_done arriving in IDLE or ISSUE is ignored.
  - A tx_ready drop in WAIT_DONE is ignored.
- Lock timeout:
  - In IDLE with locked=1, the counter increments each cycle that req_valid[grant_id]=0 and clears when it is 1.
  - When the counter reaches LOCK_TIMEOUT-1: locked<=0, rr_ptr<=grant_id+1, lock_timeout pulses 1 cycle, counter<=0. Arbitration resumes the following cycle.
  - The counter is held at 0 when unlocked.
- Simultaneous events:
  - Timeout expiry and owner valid in the same cycle: the owner is served and the counter clears.
  - rst has priority over everything.
- Reset mid-operation: all state returns to reset values next edge, with no tx_start glitch. A frame already in the transmitter is not aborted, and its late tx_done is ignored in IDLE. The requester whose byte was accepted is not re-served.
- NUM_REQ=1: degenerates to pass-through with locking; rr_ptr is constant 0.

Decomposition:
- Shared package uart_pkg:
  - Arbiter state encoding (IDLE, ISSUE, WAIT_DONE) and the TX state encoding.
  - CLK_FREQ and BAUDRATE constants and a CLKS_PER_BIT derived constant.
  - A clog2 helper.
- Sub-module rr_picker: combinational round-robin priority search.
  - Inputs: request vector, pointer, lock flag, owner.
  - Outputs: found flag and index.
  - Instantiated once and unit-testable alone.

Test Plan:
1. Single requester: req_valid[2]=1, data 0x31, last=1, tx_ready=1. Expect tx_start exactly 1 cycle later with tx_data=0x31, req_ready=0100 for 1 cycle. After tx_done: locked=0, rr_ptr=3.
2. Fairness: all 4 valid with last=1 continuously, tx_done 20 cycles after each start. Expect grant order 0,1,2,3,0, and tx_start never within 1 cycle of tx_done.
3. Locking: req0 sends 0x48, 0x69 (last on 0x69) while req1 is continuously valid with 0x41. Expect the transmitted sequence 0x48, 0x69, 0x41 and req_ready[1] low until after the second tx_done.
4. Timeout, LOCK_TIMEOUT=8: req0 sends a byte with last=0 then drops valid; req3 is valid. Expect lock_timeout pulse 8 IDLE cycles after tx_done, locked=0, and the next grant to 3 on the following cycle.
5. Reset mid-WAIT_DONE: rst for 1 cycle then a late tx_done. Expect all outputs at reset values and no tx_start until tx_ready=1 with a valid request.
6. tx_ready=0 with req_valid=1: no tx_start or req_ready for 50 cycles. When tx_ready rises, the grant follows 1 cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encodings, baud
// constants and small elaboration-time helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUDRATE     = 115_200;
  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width never drops to zero, so a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART TX arbiter, plus debug
// visibility of the arbiter state and round-robin pointer.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  import uart_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  // Handshake: a requester holds req_valid/req_data/req_last until the arbiter
  // returns a one-cycle req_ready pulse; the transmitter takes tx_data on the
  // tx_start pulse and reports completion with a one-cycle tx_done pulse.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_ready;
  logic                          tx_done;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic [ID_W-1:0]               grant_id;
  logic                          locked;
  logic                          lock_timeout;
  arb_state_e                    state_dbg;
  logic [ID_W-1:0]               rr_ptr_dbg;

  modport master (
    output req_valid, req_data, req_last, tx_ready, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, locked, lock_timeout,
           state_dbg, rr_ptr_dbg
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready, tx_done,
    output req_ready, tx_start, tx_data, grant_id, locked, lock_timeout,
           state_dbg, rr_ptr_dbg
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first valid request at or above the
// pointer (with wrap), or only the owner while a message lock is held.
module rr_picker
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               lock_i,
  input  logic [ID_W-1:0]    owner_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  always_comb begin
    logic [ID_W-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    if (lock_i) begin
      found_o = req_i[owner_i];
      idx_o   = owner_i;
    end else begin
      // Walk from the farthest candidate back so the nearest one wins.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        cand = ID_W'((int'(ptr_i) + i) % NUM_REQ);
        if (req_i[cand]) begin
          found_o = 1'b1;
          idx_o   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ requesters with round-robin
// arbitration, per-message locking and a lock watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 1000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = clog2(LOCK_TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   locked_q, locked_d;
  logic                   lock_timeout_q, lock_timeout_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_idx;
  logic [ID_W-1:0]        owner_next;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .lock_i  (locked_q),
    .owner_i (grant_id_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign owner_next = ID_W'((int'(grant_id_q) + 1) % NUM_REQ);

  always_comb begin
    state_d        = state_q;
    req_ready_d    = '0;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    grant_id_d     = grant_id_q;
    rr_ptr_d       = rr_ptr_q;
    locked_d       = locked_q;
    lock_timeout_d = 1'b0;
    last_d         = last_q;
    cnt_d          = cnt_q;

    case (state_q)
      IDLE: begin
        // Serving the owner takes precedence over an expiring watchdog.
        if (bus.tx_ready && pick_found) begin
          grant_id_d            = pick_idx;
          tx_data_d             = bus.req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          last_d                = bus.req_last[pick_idx];
          tx_start_d            = 1'b1;
          req_ready_d[pick_idx] = 1'b1;
          cnt_d                 = '0;
          state_d               = ISSUE;
        end else if (locked_q) begin
          if (bus.req_valid[grant_id_q]) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            locked_d       = 1'b0;
            rr_ptr_d       = owner_next;
            lock_timeout_d = 1'b1;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ISSUE: begin
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        cnt_d = '0;
        if (bus.tx_done) begin
          locked_d = !last_q;
          if (last_q) rr_ptr_d = owner_next;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      grant_id_q     <= '0;
      rr_ptr_q       <= '0;
      locked_q       <= 1'b0;
      lock_timeout_q <= 1'b0;
      last_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      grant_id_q     <= grant_id_d;
      rr_ptr_q       <= rr_ptr_d;
      locked_q       <= locked_d;
      lock_timeout_q <= lock_timeout_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.locked       = locked_q;
  assign bus.lock_timeout = lock_timeout_q;
  assign bus.state_dbg    = state_q;
  assign bus.rr_ptr_dbg   = rr_ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester and transmitter models, an
// expected-byte queue checked on every tx_start, and per-test timing checks.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int LT    = 8;
  localparam int ID_W  = 2;
  localparam int MAXI  = 8;
  localparam int FRAME = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- shared bench state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [ID_W+DW-1:0] exp_q[$];

  logic [DW-1:0] src_d[NR][MAXI];
  logic          src_l[NR][MAXI];
  int            src_len[NR];
  int            src_head[NR];
  bit            pend[NR];

  bit tx_hold = 1'b0;
  int busy = 0;
  int cyc = 0;
  int last_done = -100;
  bit prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- requester driver ----------------
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0;
      pend[i] = 1'b0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          src_head[i]++;
          pend[i] = 1'b0;
        end else if (bus.req_ready[i]) begin
          pend[i] = 1'b1;
        end
        if (src_head[i] < src_len[i]) begin
          bus.req_valid[i]         = 1'b1;
          bus.req_data[i*DW +: DW] = src_d[i][src_head[i]];
          bus.req_last[i]          = src_l[i][src_head[i]];
        end else begin
          bus.req_valid[i]         = 1'b0;
          bus.req_data[i*DW +: DW] = '0;
          bus.req_last[i]          = 1'b0;
        end
      end
    end
  end

  // ---------------- transmitter model ----------------
  initial begin
    bus.tx_ready = 1'b1;
    bus.tx_done  = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tx_done = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) bus.tx_done = 1'b1;
      end else if (bus.tx_start) begin
        busy = FRAME;
      end
      bus.tx_ready = (busy == 0) && !tx_hold;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [ID_W+DW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.tx_done) last_done = cyc;
      if (bus.tx_start) begin
        check("mon_start_single_cycle", {31'd0, prev_start}, 32'd0);
        check("mon_gap_after_done", {31'd0, (cyc - last_done) >= 2}, 32'd1);
        if (exp_q.size() == 0) begin
          check("mon_unexpected_start", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("mon_grant_id", {30'd0, bus.grant_id}, {30'd0, e[DW +: ID_W]});
          check("mon_tx_data", {24'd0, bus.tx_data}, {24'd0, e[DW-1:0]});
          check("mon_req_ready", {28'd0, bus.req_ready}, 32'd1 << e[DW +: ID_W]);
        end
      end
      prev_start = bus.tx_start;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic add_item(input int id, input logic [DW-1:0] d, input logic l);
    src_d[id][src_len[id]] = d;
    src_l[id][src_len[id]] = l;
    src_len[id]++;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [DW-1:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && busy == 0 && bus.state_dbg == IDLE && !bus.tx_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, n < budget}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_done && n < budget);
    check(name, {31'd0, bus.tx_done}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, {28'd0, bus.req_ready}, 32'd0);
    check({tag, "_tx_start"}, {31'd0, bus.tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
    check({tag, "_grant_id"}, {30'd0, bus.grant_id}, 32'd0);
    check({tag, "_locked"}, {31'd0, bus.locked}, 32'd0);
    check({tag, "_lock_timeout"}, {31'd0, bus.lock_timeout}, 32'd0);
    check({tag, "_state"}, {30'd0, bus.state_dbg}, {30'd0, IDLE});
    check({tag, "_rr_ptr"}, {30'd0, bus.rr_ptr_dbg}, 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int bad;
    for (int i = 0; i < NR; i++) src_len[i] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("rst0");

    // 1: single requester
    add_item(2, 8'h31, 1'b1);
    push_exp(2'd2, 8'h31);
    @(negedge clk);
    check("t1_no_start_same_cycle", {31'd0, bus.tx_start}, 32'd0);
    @(negedge clk);
    check("t1_start", {31'd0, bus.tx_start}, 32'd1);
    check("t1_req_ready", {28'd0, bus.req_ready}, 32'b0100);
    @(negedge clk);
    check("t1_start_dropped", {31'd0, bus.tx_start}, 32'd0);
    check("t1_ready_dropped", {28'd0, bus.req_ready}, 32'd0);
    wait_done("t1_done_seen", 40);
    @(negedge clk);
    check("t1_unlocked", {31'd0, bus.locked}, 32'd0);
    check("t1_rr_ptr", {30'd0, bus.rr_ptr_dbg}, 32'd3);
    wait_idle("t1_idle", 50);

    // 2: fairness with everyone valid
    do_reset();
    add_item(0, 8'hA0, 1'b1);
    add_item(0, 8'hA4, 1'b1);
    add_item(1, 8'hA1, 1'b1);
    add_item(2, 8'hA2, 1'b1);
    add_item(3, 8'hA3, 1'b1);
    push_exp(2'd0, 8'hA0);
    push_exp(2'd1, 8'hA1);
    push_exp(2'd2, 8'hA2);
    push_exp(2'd3, 8'hA3);
    push_exp(2'd0, 8'hA4);
    wait_idle("t2_idle", 500);

    // 3: message locking
    do_reset();
    add_item(0, 8'h48, 1'b0);
    add_item(0, 8'h69, 1'b1);
    add_item(1, 8'h41, 1'b1);
    push_exp(2'd0, 8'h48);
    push_exp(2'd0, 8'h69);
    push_exp(2'd1, 8'h41);
    wait_done("t3_first_done", 40);
    @(negedge clk);
    check("t3_locked", {31'd0, bus.locked}, 32'd1);
    check("t3_owner", {30'd0, bus.grant_id}, 32'd0);
    wait_done("t3_second_done", 60);
    @(negedge clk);
    check("t3_unlocked", {31'd0, bus.locked}, 32'd0);
    wait_idle("t3_idle", 100);

    // 4: lock timeout with LOCK_TIMEOUT=8
    do_reset();
    add_item(0, 8'h55, 1'b0);
    add_item(3, 8'h77, 1'b1);
    push_exp(2'd0, 8'h55);
    push_exp(2'd3, 8'h77);
    wait_done("t4_done", 40);
    bad = 0;
    for (int i = 0; i < LT; i++) begin
      @(negedge clk);
      if (bus.lock_timeout !== 1'b0 || bus.locked !== 1'b1 || bus.tx_start !== 1'b0) bad++;
    end
    check("t4_silent_window", bad, 32'd0);
    @(negedge clk);
    check("t4_timeout_pulse", {31'd0, bus.lock_timeout}, 32'd1);
    check("t4_unlocked", {31'd0, bus.locked}, 32'd0);
    check("t4_rr_ptr", {30'd0, bus.rr_ptr_dbg}, 32'd1);
    @(negedge clk);
    check("t4_timeout_single", {31'd0, bus.lock_timeout}, 32'd0);
    check("t4_next_start", {31'd0, bus.tx_start}, 32'd1);
    check("t4_next_grant", {30'd0, bus.grant_id}, 32'd3);
    wait_idle("t4_idle", 60);

    // 5: reset while waiting for tx_done
    do_reset();
    add_item(1, 8'h5A, 1'b1);
    push_exp(2'd1, 8'h5A);
    bad = 0;
    while (bus.state_dbg != WAIT_DONE && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    check("t5_reached_wait", {30'd0, bus.state_dbg}, {30'd0, WAIT_DONE});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("t5_rst");
    wait_done("t5_late_done", 40);
    @(negedge clk);
    check("t5_still_idle", {30'd0, bus.state_dbg}, {30'd0, IDLE});
    check("t5_no_lock", {31'd0, bus.locked}, 32'd0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.tx_start !== 1'b0 || bus.req_ready !== '0) bad++;
    end
    check("t5_no_reserve", bad, 32'd0);
    add_item(2, 8'h99, 1'b1);
    push_exp(2'd2, 8'h99);
    wait_idle("t5_idle", 60);

    // 6: transmitter not ready
    do_reset();
    tx_hold = 1'b1;
    add_item(1, 8'h42, 1'b1);
    push_exp(2'd1, 8'h42);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx_start !== 1'b0 || bus.req_ready !== '0) bad++;
    end
    check("t6_blocked", bad, 32'd0);
    tx_hold = 1'b0;
    @(negedge clk);
    check("t6_no_start_on_rise", {31'd0, bus.tx_start}, 32'd0);
    @(negedge clk);
    check("t6_start_after_rise", {31'd0, bus.tx_start}, 32'd1);
    check("t6_req_ready", {28'd0, bus.req_ready}, 32'b0010);
    wait_idle("t6_idle", 60);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
